// File: rtl/ari_tx_pkt_arbiter.sv
// Packet-level arbiter that shares the PCS ari TX port between two sources, with an idle gap and a beat watchdog.
// Build option: define ARB_FIXED_PRIORITY_EN to make requester 0 win every simultaneous request.
module ari_tx_pkt_arbiter #(
  parameter int DATA_W        = 32,
  parameter int BE_W          = 2,
  parameter int MAX_PKT_WORDS = 1024,
  parameter int GAP_CYCLES    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_val,
  input  logic              i_req0_sof,
  input  logic              i_req0_eof,
  input  logic [BE_W-1:0]   i_req0_be,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ack,
  input  logic [15:0]       i_req0_frame_len,
  input  logic              i_req0_frame_len_val,
  input  logic              i_req1_val,
  input  logic              i_req1_sof,
  input  logic              i_req1_eof,
  input  logic [BE_W-1:0]   i_req1_be,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ack,
  input  logic [15:0]       i_req1_frame_len,
  input  logic              i_req1_frame_len_val,
  output logic              o_ari_val,
  output logic              o_ari_sof,
  output logic              o_ari_eof,
  output logic [BE_W-1:0]   o_ari_be,
  output logic [DATA_W-1:0] o_ari_data,
  input  logic              i_ari_ack,
  output logic [15:0]       o_ari_frame_len,
  output logic              o_ari_frame_len_val,
  output logic [1:0]        o_grant,
  output logic              o_timeout,
  output logic [15:0]       o_pkt_cnt0,
  output logic [15:0]       o_pkt_cnt1,
  output logic [15:0]       o_drop_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam int BEAT_W = $clog2(MAX_PKT_WORDS + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_PKT_WORDS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [1:0] ST_DONE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam logic RR_EN = 1'b0;
`else
  localparam logic RR_EN = 1'b1;
`endif

  logic [1:0]        state;
  logic [1:0]        grant;
  logic              rr;
  logic [BEAT_W-1:0] beat_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              timeout;
  logic [15:0]       pkt_cnt0, pkt_cnt1, drop_cnt;

  logic              sel_val, sel_sof, sel_eof, sel_flv;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_data;
  logic [15:0]       sel_flen;

  // Grant is only non-zero in XFER, so a zero grant also forces the idle/gap outputs.
  always_comb begin
    sel_val  = 1'b0;
    sel_sof  = 1'b0;
    sel_eof  = 1'b0;
    sel_be   = '0;
    sel_data = '0;
    sel_flen = '0;
    sel_flv  = 1'b0;
    if (grant[0]) begin
      sel_val  = i_req0_val;
      sel_sof  = i_req0_sof;
      sel_eof  = i_req0_eof;
      sel_be   = i_req0_be;
      sel_data = i_req0_data;
      sel_flen = i_req0_frame_len;
      sel_flv  = i_req0_frame_len_val;
    end else if (grant[1]) begin
      sel_val  = i_req1_val;
      sel_sof  = i_req1_sof;
      sel_eof  = i_req1_eof;
      sel_be   = i_req1_be;
      sel_data = i_req1_data;
      sel_flen = i_req1_frame_len;
      sel_flv  = i_req1_frame_len_val;
    end
  end

  logic        in_idle, cand0, cand1, flush0, flush1, pick1, beat_xfer;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign in_idle   = (state == ST_IDLE);
  assign cand0     = i_req0_val & i_req0_sof;
  assign cand1     = i_req1_val & i_req1_sof;
  assign flush0    = in_idle & i_req0_val & ~i_req0_sof;
  assign flush1    = in_idle & i_req1_val & ~i_req1_sof;
  // rr holds the last owner; the other requester wins a tie.
  assign pick1     = cand1 & (~cand0 | (RR_EN & ~rr));
  assign beat_xfer = sel_val & i_ari_ack;
  assign drop_inc  = {1'b0, flush0} + {1'b0, flush1};
  assign drop_sum  = {1'b0, drop_cnt} + {15'd0, drop_inc};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      grant    <= 2'b00;
      rr       <= 1'b1;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      timeout  <= 1'b0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      drop_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      if (flush0 | flush1)
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        ST_IDLE: if (cand0 | cand1) begin
          grant    <= pick1 ? 2'b10 : 2'b01;
          beat_cnt <= '0;
          state    <= ST_XFER;
        end
        ST_XFER: if (beat_xfer) begin
          // Packet ends on eof or when the watchdog beat limit is reached.
          if (sel_eof || beat_cnt == BEAT_LAST) begin
            grant   <= 2'b00;
            rr      <= grant[1];
            gap_cnt <= '0;
            state   <= ST_DONE;
            timeout <= ~sel_eof;
            if (sel_eof & grant[0]) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (sel_eof & grant[1]) pkt_cnt1 <= pkt_cnt1 + 16'd1;
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_req0_ack          = (i_ari_ack & grant[0]) | flush0;
  assign o_req1_ack          = (i_ari_ack & grant[1]) | flush1;
  assign o_ari_val           = sel_val;
  assign o_ari_sof           = sel_sof;
  assign o_ari_eof           = sel_eof;
  assign o_ari_be            = sel_be;
  assign o_ari_data          = sel_data;
  assign o_ari_frame_len     = sel_flen;
  assign o_ari_frame_len_val = sel_flv;
  assign o_grant             = grant;
  assign o_timeout           = timeout;
  assign o_pkt_cnt0          = pkt_cnt0;
  assign o_pkt_cnt1          = pkt_cnt1;
  assign o_drop_cnt          = drop_cnt;

endmodule

// File: doc/ari_tx_pkt_arbiter.md
Name: ari_tx_pkt_arbiter

Overview:
Packet-level round-robin arbiter that shares the single PCS_TOP ari TX port between two packet sources, for example the SGDMA bridge and a test pattern source. A grant is locked from an accepted SOF beat until the matching accepted EOF beat. Packets are never interleaved. A minimum idle gap is inserted between packets, and a beat-count watchdog frees the port if a source stalls mid-packet. It sits between the ari-side source adapters and PCS_TOP i_ari_*, in the i_vl_tx_clk domain.

Parameters:
DATA_W, 32, ari data width
BE_W, 2, ari byte-enable width
MAX_PKT_WORDS, 1024, watchdog limit on accepted beats per packet
GAP_CYCLES, 4, idle cycles forced after each packet (0 allowed)

Ports:
i_clk  in  1  i_vl_tx_clk domain clock
i_rst_n  in  1  async active-low reset
i_req0_val / i_req0_sof / i_req0_eof  in  1 each  requester 0 beat qualifiers
i_req0_be  in  BE_W  requester 0 byte enables
i_req0_data  in  DATA_W  requester 0 data
o_req0_ack  out  1  requester 0 beat accepted
i_req0_frame_len  in  16  requester 0 frame length
i_req0_frame_len_val  in  1  requester 0 frame length valid
i_req1_*, o_req1_ack  same set for requester 1
o_ari_val / o_ari_sof / o_ari_eof  out  1 each  to PCS
o_ari_be  out  BE_W  to PCS
o_ari_data  out  DATA_W  to PCS
i_ari_ack  in  1  from PCS
o_ari_frame_len  out  16  to PCS
o_ari_frame_len_val  out  1  to PCS
o_grant  out  2  one-hot current owner; 00 when not locked
o_timeout  out  1  one-cycle pulse on watchdog abort
o_pkt_cnt0, o_pkt_cnt1  out  16  completed packets per requester, wrapping
o_drop_cnt  out  16  discarded orphan beats, saturating

Behaviour:
- Reset: async, active-low. State=IDLE, rr pointer=1 so requester 0 wins first, o_grant=00, all o_ari_* = 0, both acks 0, all counters 0, o_timeout 0.
- Beat transfer: a beat transfers when the granted requester's val is high and i_ari_ack is high in the same cycle.
- Datapath: combinational mux selected by the registered grant. Zero-cycle latency, no buffering.
- o_reqN_ack = i_ari_ack & grant[N]. The non-granted requester sees ack=0.
- o_ari_frame_len / o_ari_frame_len_val are muxed by grant. frame_len_val is forced to 0 when o_grant=00.
- State IDLE:
  - Candidates are requesters with val=1 and sof=1.
  - Round-robin: when both are candidates, the one not equal to the rr pointer wins.
  - The winner's grant registers on the next edge, then the state goes to XFER. Its first beat is presented in XFER, not IDLE.
  - IDLE outputs o_ari_val=0.
  - Orphan beats (val=1, sof=0) while in IDLE are flushed: ack=1 to that requester, o_drop_cnt+1 per beat, nothing is forwarded.
  - If one requester is a candidate and the other has an orphan beat in the same cycle, the grant is issued and the orphan is flushed.
- State XFER:
  - Beat counter increments per transferred beat.
  - On a transferred beat with eof=1: pkt_cntN+1, rr pointer=owner, grant cleared, go to GAP (or IDLE if GAP_CYCLES=0).
  - A single-beat packet (sof=1, eof=1) is legal.
  - A sof=1 beat after the first beat is forwarded unchanged; the grant is not reset.
- Watchdog:
  - If MAX_PKT_WORDS beats have transferred without eof, abort: grant cleared, o_timeout pulses one cycle, rr pointer=owner, go to GAP.
  - The remaining beats of the aborted packet arrive in IDLE as orphans and are flushed.
- State GAP: o_ari_val=0, both acks 0. Counts GAP_CYCLES cycles, then goes to IDLE.
- Backpressure: i_ari_ack=0 holds all state. The beat counter does not advance, and the watchdog counts beats, not cycles.
- Reset mid-packet: immediate return to IDLE with o_ari_val=0. The partial packet is lost. PCS-side framing recovery belongs to the PCS.
- Widths: the beat counter is wide enough for MAX_PKT_WORDS. pkt_cnt wraps at 16 bits. drop_cnt saturates at 0xFFFF.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: requester 0 always wins simultaneous candidacy; the rr pointer is ignored (still updated, but unused).
- Undefined: round-robin as specified above.
- Packet lock, gap, watchdog and counters are identical in both builds.

Test Plan:
- Single source: req0 sends a 16-beat packet, i_ari_ack=1 → o_grant=01, 16 beats forwarded in order, pkt_cnt0=1, then 4 gap cycles with o_ari_val=0.
- Contention: both sources hold sof continuously, each with 8-beat packets, for 6 packets → grant order 0,1,0,1,0,1, no interleaving, pkt_cnt0=pkt_cnt1=3. With ARB_FIXED_PRIORITY_EN: all 6 packets go to req0.
- Backpressure: toggle i_ari_ack 50% during a 1024-beat packet → no timeout, exactly 1024 beats delivered, data sequence intact.
- Watchdog: MAX_PKT_WORDS=32, req1 sends 40 beats with eof on beat 40 → o_timeout pulses after beat 32, remaining 8 beats are flushed, o_drop_cnt=8, pkt_cnt1=0.
- Orphans: req0 presents 3 beats with sof=0 while in IDLE → 3 acks, o_ari_val stays 0, o_drop_cnt=3.
- Reset mid-packet: deassert i_rst_n at beat 5 of 10 → outputs go to reset values asynchronously; after release a fresh sof packet is granted normally.
